// File: rtl/video_pattern_gen.sv
// video_pattern_gen: self-timed raster source with four
// run-time selectable test patterns and a completed-frame counter.
module video_pattern_gen #(
   parameter int DSIZE    = 24,
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36
) (
   input  logic             pclk,
   input  logic             prst,
   input  logic             enable,
   input  logic [1:0]       pattern,
   input  logic [DSIZE-1:0] solid_color,
   output logic             vsync,
   output logic             hsync,
   output logic             de,
   output logic [DSIZE-1:0] data,
   output logic [15:0]      frame_cnt,
   output logic [15:0]      vactive,
   output logic [15:0]      hactive
);

   localparam int CW      = DSIZE / 3;
   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
   localparam logic [15:0] H_SYNC_W = 16'(H_SYNC);
   localparam logic [15:0] V_SYNC_W = 16'(V_SYNC);
   localparam logic [15:0] H_START  = 16'(H_SYNC + H_BP);
   localparam logic [15:0] H_END    = 16'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [15:0] V_START  = 16'(V_SYNC + V_BP);
   localparam logic [15:0] V_END    = 16'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       r_state;
   logic [15:0]      r_hcnt;
   logic [15:0]      r_vcnt;
   logic [2:0]       r_bar;
   logic [15:0]      r_bar_sub;
   logic [1:0]       r_pat;
   logic [DSIZE-1:0] r_solid;
   logic [15:0]      r_frame_cnt;
   logic             r_vsync;
   logic             r_hsync;
   logic             r_de;
   logic [DSIZE-1:0] r_data;

   logic             w_run;
   logic             w_start;
   logic             w_h_last;
   logic             w_v_last;
   logic             w_frame_end;
   logic             w_latch;
   logic [15:0]      w_hcnt_nxt;
   logic [15:0]      w_vcnt_nxt;
   logic [15:0]      w_px;
   logic [15:0]      w_ln;
   logic             w_in_h;
   logic             w_in_v;
   logic             w_de;
   logic [CW-1:0]    w_ramp;
   logic [DSIZE-1:0] w_pix;

   assign w_run       = (r_state == ST_RUN);
   assign w_start     = (r_state == ST_IDLE) & enable;
   assign w_h_last    = (r_hcnt == H_LAST);
   assign w_v_last    = (r_vcnt == V_LAST);
   assign w_frame_end = w_run & w_h_last & w_v_last;
   assign w_latch     = w_start |
                        (w_run & (r_hcnt == 16'd0) & (r_vcnt == 16'd0));

   assign w_hcnt_nxt = w_h_last ? 16'd0 : r_hcnt + 16'd1;
   assign w_vcnt_nxt = !w_h_last ? r_vcnt :
                       (w_v_last ? 16'd0 : r_vcnt + 16'd1);

   assign w_px   = r_hcnt - H_START;
   assign w_ln   = r_vcnt - V_START;
   assign w_in_h = (r_hcnt >= H_START) & (r_hcnt < H_END);
   assign w_in_v = (r_vcnt >= V_START) & (r_vcnt < V_END);
   assign w_de   = w_run & w_in_h & w_in_v;
   assign w_ramp = CW'(w_px) + CW'(w_ln);

   // Run/idle control; a stop only takes effect on a frame's last clock
   always_ff @(posedge pclk) begin
      if (prst) begin
         r_state <= ST_IDLE;
         r_hcnt  <= 16'd0;
         r_vcnt  <= 16'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_hcnt <= 16'd0;
               r_vcnt <= 16'd0;
               if (enable)
                  r_state <= ST_RUN;
            end
            default: begin
               r_hcnt <= w_hcnt_nxt;
               r_vcnt <= w_vcnt_nxt;
               if (w_frame_end && !enable)
                  r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Bar index tracked alongside hcnt so no divider is needed
   always_ff @(posedge pclk) begin
      if (prst || !w_run) begin
         r_bar     <= 3'd0;
         r_bar_sub <= 16'd0;
      end else if (w_hcnt_nxt == H_START) begin
         r_bar     <= 3'd0;
         r_bar_sub <= 16'd0;
      end else if (r_bar_sub == BAR_LAST) begin
         r_bar     <= r_bar + 3'd1;
         r_bar_sub <= 16'd0;
      end else begin
         r_bar_sub <= r_bar_sub + 16'd1;
      end
   end

   // Per-frame shadow of the pattern controls
   always_ff @(posedge pclk) begin
      if (prst) begin
         r_pat   <= 2'd0;
         r_solid <= '0;
      end else if (w_latch) begin
         r_pat   <= pattern;
         r_solid <= solid_color;
      end
   end

   // Completed-frame counter, cleared only by reset
   always_ff @(posedge pclk) begin
      if (prst)
         r_frame_cnt <= 16'd0;
      else if (w_frame_end)
         r_frame_cnt <= r_frame_cnt + 16'd1;
   end

   // Pixel value for the current position and latched pattern
   always_comb begin
      w_pix = '0;
      unique case (r_pat)
         2'd0: w_pix = DSIZE'({w_ln, w_px});
         2'd1: w_pix = {{CW{~r_bar[1]}},
                        {CW{~r_bar[2]}},
                        {CW{~r_bar[0]}}};
         2'd2: w_pix = {3{w_ramp}};
         default: w_pix = r_solid;
      endcase
   end

   // Registered sync, enable and data outputs
   always_ff @(posedge pclk) begin
      if (prst || !w_run) begin
         r_vsync <= 1'b0;
         r_hsync <= 1'b0;
         r_de    <= 1'b0;
         r_data  <= '0;
      end else begin
         r_vsync <= (r_vcnt < V_SYNC_W);
         r_hsync <= (r_hcnt < H_SYNC_W);
         r_de    <= w_de;
         r_data  <= w_de ? w_pix : '0;
      end
   end

   assign vsync     = r_vsync;
   assign hsync     = r_hsync;
   assign de        = r_de;
   assign data      = r_data;
   assign frame_cnt = r_frame_cnt;
   assign vactive   = 16'(V_ACTIVE);
   assign hactive   = 16'(H_ACTIVE);

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: table vectors, directed corner cases and
// randomized control against a frame-position reference model.
module tb_video_pattern_gen;

   localparam int DS  = 24;
   localparam int HA  = 16;
   localparam int HF  = 2;
   localparam int HS  = 2;
   localparam int HB  = 2;
   localparam int VA  = 4;
   localparam int VF  = 1;
   localparam int VS  = 1;
   localparam int VB  = 1;
   localparam int HT  = HS + HB + HA + HF;
   localparam int VT  = VS + VB + VA + VF;
   localparam int FT  = HT * VT;
   localparam int HST = HS + HB;
   localparam int VST = VS + VB;

   logic          pclk = 1'b0;
   logic          prst = 1'b1;
   logic          enable = 1'b0;
   logic [1:0]    pattern = 2'd0;
   logic [DS-1:0] solid_color = '0;
   logic          vsync;
   logic          hsync;
   logic          de;
   logic [DS-1:0] data;
   logic [15:0]   frame_cnt;
   logic [15:0]   vactive;
   logic [15:0]   hactive;

   int errors = 0;
   int checks = 0;

   bit            m_run = 1'b0;
   int            m_pos = 0;
   int            m_pat = 0;
   logic [DS-1:0] m_solid = '0;
   int            m_fc = 0;

   typedef struct {
      logic [1:0]  pat;
      logic [23:0] sol;
      int          ln;
      int          px;
      logic        de;
      logic [23:0] dat;
   } vec_t;

   vec_t vt[14];

   video_pattern_gen #(
      .DSIZE(DS), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .pclk(pclk), .prst(prst), .enable(enable), .pattern(pattern),
      .solid_color(solid_color), .vsync(vsync), .hsync(hsync),
      .de(de), .data(data), .frame_cnt(frame_cnt),
      .vactive(vactive), .hactive(hactive)
   );

   always #5 pclk = ~pclk;

   function automatic logic [23:0] ref_pix(int pat, logic [23:0] sol,
                                           int px, int ln);
      int bar;
      int v;
      logic [7:0] c;
      case (pat)
         0: return 24'(ln * 65536 + px);
         1: begin
            bar = px / (HA / 8);
            case (bar)
               0: return 24'hFFFFFF;
               1: return 24'hFFFF00;
               2: return 24'h00FFFF;
               3: return 24'h00FF00;
               4: return 24'hFF00FF;
               5: return 24'hFF0000;
               6: return 24'h0000FF;
               default: return 24'h000000;
            endcase
         end
         2: begin
            v = (px + ln) % 256;
            c = 8'(v);
            return {c, c, c};
         end
         default: return sol;
      endcase
   endfunction

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   // One clock: predict outputs, advance model, compare after the edge
   task automatic step();
      logic [42:0] e;
      int line;
      int col;
      bit d;
      e = '0;
      if (!prst && m_run) begin
         line = m_pos / HT;
         col  = m_pos % HT;
         d = (col >= HST) && (col < HST + HA) &&
             (line >= VST) && (line < VST + VA);
         e[42] = (line < VS);
         e[41] = (col < HS);
         e[40] = d;
         if (d)
            e[39:16] = ref_pix(m_pat, m_solid, col - HST, line - VST);
      end
      if (prst) begin
         m_run = 1'b0;
         m_pos = 0;
         m_fc = 0;
         m_pat = 0;
         m_solid = '0;
      end else if (!m_run) begin
         if (enable) begin
            m_run = 1'b1;
            m_pos = 0;
            m_pat = int'(pattern);
            m_solid = solid_color;
         end
      end else begin
         if (m_pos == 0) begin
            m_pat = int'(pattern);
            m_solid = solid_color;
         end
         if (m_pos == FT - 1) begin
            m_fc = (m_fc + 1) % 65536;
            m_pos = 0;
            if (!enable)
               m_run = 1'b0;
         end else begin
            m_pos++;
         end
      end
      e[15:0] = 16'(m_fc);
      @(posedge pclk);
      #1;
      check("raster", 64'({vsync, hsync, de, data, frame_cnt}), 64'(e));
   endtask

   initial begin
      int hs_n;
      int vs_n;
      int de_n;
      int hit;
      int k;
      int n;
      int bad;

      vt[0]  = '{2'd0, 24'h0, 1, 3, 1'b1, 24'h010003};
      vt[1]  = '{2'd1, 24'h0, 0, 0, 1'b1, 24'hFFFFFF};
      vt[2]  = '{2'd1, 24'h0, 0, 1, 1'b1, 24'hFFFFFF};
      vt[3]  = '{2'd1, 24'h0, 1, 2, 1'b1, 24'hFFFF00};
      vt[4]  = '{2'd1, 24'h0, 1, 3, 1'b1, 24'hFFFF00};
      vt[5]  = '{2'd1, 24'h0, 2, 14, 1'b1, 24'h000000};
      vt[6]  = '{2'd1, 24'h0, 3, 15, 1'b1, 24'h000000};
      vt[7]  = '{2'd1, 24'h0, 0, -1, 1'b0, 24'h000000};
      vt[8]  = '{2'd2, 24'h0, 3, 5, 1'b1, 24'h080808};
      vt[9]  = '{2'd2, 24'h0, 3, 15, 1'b1, 24'h121212};
      vt[10] = '{2'd3, 24'hABCDEF, 2, 7, 1'b1, 24'hABCDEF};
      vt[11] = '{2'd1, 24'h0, 0, 8, 1'b1, 24'hFF00FF};
      vt[12] = '{2'd0, 24'h0, 3, 15, 1'b1, 24'h03000F};
      vt[13] = '{2'd1, 24'h0, 0, 16, 1'b0, 24'h000000};

      // Reset state
      prst = 1'b1;
      step();
      step();
      check("reset_out", 64'({vsync, hsync, de, data, frame_cnt}), 64'd0);
      check("vactive", 64'(vactive), 64'd4);
      check("hactive", 64'(hactive), 64'd16);
      prst = 1'b0;
      step();

      // Geometry over one frame with the counter pattern
      pattern = 2'd0;
      enable = 1'b1;
      step();
      check("pre_sync", 64'({vsync, hsync}), 64'd0);
      hs_n = 0;
      vs_n = 0;
      de_n = 0;
      for (int i = 1; i <= FT; i++) begin
         step();
         hs_n += int'(hsync);
         vs_n += int'(vsync);
         de_n += int'(de);
         if (i == 1)
            check("first_sync", 64'({vsync, hsync}), 64'd3);
         if (i == 48)
            check("de_before", 64'(de), 64'd0);
         if (i == 49)
            check("de_first", 64'(de), 64'd1);
         if (i == FT - 1)
            check("fc_before", 64'(frame_cnt), 64'd0);
      end
      check("fc_one", 64'(frame_cnt), 64'd1);
      check("hsync_count", 64'(hs_n), 64'd14);
      check("vsync_count", 64'(vs_n), 64'd22);
      check("de_count", 64'(de_n), 64'd64);

      // Table vectors: fresh start, then land on one raster position
      for (int i = 0; i < 14; i++) begin
         prst = 1'b1;
         step();
         prst = 1'b0;
         pattern = vt[i].pat;
         solid_color = vt[i].sol;
         enable = 1'b1;
         step();
         k = (VST + vt[i].ln) * HT + HST + vt[i].px;
         for (int j = 0; j <= k; j++)
            step();
         check($sformatf("vec%0d", i), 64'({de, data}),
               64'({vt[i].de, vt[i].dat}));
      end

      // Pattern change mid-frame
      prst = 1'b1;
      step();
      prst = 1'b0;
      pattern = 2'd2;
      solid_color = 24'h0;
      enable = 1'b1;
      step();
      for (int j = 1; j <= 3 * HT; j++)
         step();
      pattern = 2'd3;
      solid_color = 24'h123456;
      hit = 0;
      for (int j = 3 * HT + 1; j <= FT; j++) begin
         step();
         if (de && data == 24'h123456)
            hit++;
      end
      check("old_frame_pat", 64'(hit), 64'd0);
      hit = 0;
      for (int j = 1; j <= FT; j++) begin
         step();
         if (de && data == 24'h123456)
            hit++;
      end
      check("new_frame_pat", 64'(hit), 64'd64);

      // Enable dropped mid-frame: frame completes then holds
      for (int j = 0; j < 40; j++)
         step();
      enable = 1'b0;
      n = 0;
      while (m_run && n < 400) begin
         step();
         n++;
      end
      check("stop_bound", 64'(n < 400), 64'd1);
      check("fc_stop", 64'(frame_cnt), 64'd3);
      bad = 0;
      for (int j = 0; j < 30; j++) begin
         step();
         if ({vsync, hsync, de} != 3'b0 || data != 24'h0 ||
             frame_cnt != 16'd3)
            bad++;
      end
      check("idle_hold", 64'(bad), 64'd0);
      enable = 1'b1;
      step();
      check("reen_e0", 64'({vsync, hsync}), 64'd0);
      step();
      check("reen_sync", 64'({vsync, hsync}), 64'd3);

      // Reset pulse at line 3 pixel 7
      n = 0;
      while (m_pos != 3 * HT + 7 && n < 400) begin
         step();
         n++;
      end
      check("prst_seek", 64'(n < 400), 64'd1);
      prst = 1'b1;
      step();
      check("prst_clear", 64'({vsync, hsync, de, data, frame_cnt}),
            64'd0);
      prst = 1'b0;
      step();
      check("prst_e0", 64'({vsync, hsync}), 64'd0);
      step();
      check("prst_restart", 64'({vsync, hsync, de}), 64'd6);

      // Randomized control against the model
      for (int j = 0; j < 3000; j++) begin
         if ($urandom_range(0, 49) == 0)
            pattern = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0)
            solid_color = 24'($urandom);
         enable = ($urandom_range(0, 9) != 0);
         prst = ($urandom_range(0, 999) == 0);
         step();
      end
      prst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
